// File: rtl/bsg_mux_one_hot_buffered.sv
// One-hot element mux feeding a 2-entry valid/yumi FIFO.
// Define BSG_MUX_ONE_HOT_SEL_CHECK_EN to enable select-error flag and counter.
module bsg_mux_one_hot_buffered #(
  parameter int width_p         = 9,
  parameter int els_p           = 5,
  parameter int err_cnt_width_p = 8
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         v_i,
  output logic                         ready_o,
  input  logic [els_p*width_p-1:0]     data_i,
  input  logic [els_p-1:0]             sel_one_hot_i,
  output logic                         v_o,
  output logic [width_p-1:0]           data_o,
  input  logic                         yumi_i,
  output logic                         err_o,
  output logic [err_cnt_width_p-1:0]   err_cnt_o
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e             r_state;
  logic [width_p-1:0] r_head;
  logic [width_p-1:0] r_tail;
  logic [width_p-1:0] w_mux;
  logic               w_enq;
  logic               w_deq;

  always_comb begin
    w_mux = '0;
    for (int k = 0; k < els_p; k++) begin
      w_mux = w_mux
        | (data_i[k*width_p +: width_p]
           & {width_p{sel_one_hot_i[k]}});
    end
  end

  assign ready_o = (r_state != FULL);
  assign v_o     = (r_state != EMPTY);
  assign data_o  = v_o ? r_head : '0;
  assign w_enq   = v_i & ready_o;
  assign w_deq   = yumi_i & v_o;

  // Head is always the oldest beat; tail only holds when FULL.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= EMPTY;
      r_head  <= '0;
      r_tail  <= '0;
    end else begin
      unique case (r_state)
        EMPTY: begin
          if (w_enq) begin
            r_head  <= w_mux;
            r_state <= ONE;
          end
        end
        ONE: begin
          unique case ({w_enq, w_deq})
            2'b11: r_head <= w_mux;
            2'b10: begin
              r_tail  <= w_mux;
              r_state <= FULL;
            end
            2'b01: r_state <= EMPTY;
            default: ;
          endcase
        end
        FULL: begin
          if (w_deq) begin
            r_head  <= r_tail;
            r_state <= ONE;
          end
        end
        default: r_state <= EMPTY;
      endcase
    end
  end

  a_yumi_needs_valid: assert property (
    @(posedge clk_i) disable iff (reset_i)
      !(yumi_i && !v_o)
  );

`ifdef BSG_MUX_ONE_HOT_SEL_CHECK_EN
  logic                       w_sel_bad;
  logic                       r_err;
  logic [err_cnt_width_p-1:0] r_err_cnt;

  // Zero bits set, or clearing the lowest set bit leaves another.
  assign w_sel_bad = w_enq
    & ((sel_one_hot_i == '0)
       | ((sel_one_hot_i
           & (sel_one_hot_i - els_p'(1))) != '0));

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else if (w_sel_bad) begin
      r_err <= 1'b1;
      if (~&r_err_cnt)
        r_err_cnt <= r_err_cnt + err_cnt_width_p'(1);
    end
  end

  assign err_o     = r_err;
  assign err_cnt_o = r_err_cnt;
`else
  assign err_o     = 1'b0;
  assign err_cnt_o = '0;
`endif

endmodule

// File: tb/tb_bsg_mux_one_hot_buffered.sv
// Bench for bsg_mux_one_hot_buffered: queue model plus directed literals.
module tb_bsg_mux_one_hot_buffered;
  localparam int W  = 9;
  localparam int E  = 5;
  localparam int CW = 8;
`ifdef BSG_MUX_ONE_HOT_SEL_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_i = 1'b1;
  logic          v_i = 1'b0;
  logic          yumi_i = 1'b0;
  logic [E*W-1:0] data_i;
  logic [E-1:0]  sel = '0;
  logic          ready_o, v_o, err_o;
  logic [W-1:0]  data_o;
  logic [CW-1:0] err_cnt_o;

  logic [W-1:0] elems [E];

  int tests = 0;
  int fails = 0;

  bsg_mux_one_hot_buffered #(
    .width_p(W), .els_p(E), .err_cnt_width_p(CW)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .v_i(v_i),
    .ready_o(ready_o), .data_i(data_i),
    .sel_one_hot_i(sel), .v_o(v_o), .data_o(data_o),
    .yumi_i(yumi_i), .err_o(err_o), .err_cnt_o(err_cnt_o)
  );

  always #5 clk = ~clk;

  function automatic void chk(string n, logic [31:0] a,
                              logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               n, a, e, $time);
    end
  endfunction

  // Model: FIFO as a queue of selected values, error count as an int.
  logic [W-1:0] mq[$];
  bit           m_err = 1'b0;
  int           m_cnt = 0;
  bit           armed = 1'b0;

  always @(posedge clk) begin
    bit           acc;
    logic [W-1:0] r;
    armed = 1'b1;
    if (reset_i) begin
      mq.delete();
      m_err = 1'b0;
      m_cnt = 0;
    end else begin
      acc = v_i && (mq.size() < 2);
      r = '0;
      for (int k = 0; k < E; k++)
        if (sel[k]) r = r | elems[k];
      if (yumi_i && mq.size() > 0) void'(mq.pop_front());
      if (acc) begin
        mq.push_back(r);
        if (CHK && $countones(sel) != 1) begin
          m_err = 1'b1;
          if (m_cnt < (1 << CW) - 1) m_cnt++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("m_v_o", v_o, mq.size() != 0);
      chk("m_ready_o", ready_o, mq.size() < 2);
      chk("m_data_o", data_o, mq.size() != 0 ? mq[0] : '0);
      chk("m_err_o", err_o, m_err);
      chk("m_err_cnt_o", err_cnt_o, m_cnt);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  int outs;
  int rdy_ok;

  initial begin
    elems[0] = 9'h101;
    elems[1] = 9'h0A2;
    elems[2] = 9'h1FF;
    elems[3] = 9'h033;
    elems[4] = 9'h144;
    for (int k = 0; k < E; k++) data_i[k*W +: W] = elems[k];

    tick();
    tick();
    reset_i = 1'b0;
    look();
    chk("rst_v_o", v_o, 0);
    chk("rst_ready_o", ready_o, 1);
    chk("rst_data_o", data_o, 0);
    chk("rst_err_o", err_o, 0);
    chk("rst_err_cnt", err_cnt_o, 0);

    // basic select
    v_i = 1'b1; sel = 5'b01000;
    tick();
    v_i = 1'b0; yumi_i = 1'b1;
    look();
    chk("basic_v_o", v_o, 1);
    chk("basic_data", data_o, 9'h033);
    tick();
    yumi_i = 1'b0;
    look();
    chk("basic_v_o_after", v_o, 0);
    chk("basic_data_after", data_o, 0);

    // backpressure
    v_i = 1'b1; sel = 5'b00001;
    tick();
    sel = 5'b00010;
    tick();
    sel = 5'b00100;
    look();
    chk("bp_ready_full", ready_o, 0);
    tick();
    v_i = 1'b0; yumi_i = 1'b1;
    look();
    chk("bp_first", data_o, 9'h101);
    tick();
    look();
    chk("bp_second", data_o, 9'h0A2);
    tick();
    yumi_i = 1'b0;
    look();
    chk("bp_drained", v_o, 0);

    // streaming
    v_i = 1'b1; sel = 5'b00001;
    tick();
    outs = 0;
    rdy_ok = 0;
    for (int i = 1; i <= 10; i++) begin
      sel = 5'b00001 << (i % 5);
      yumi_i = 1'b1;
      look();
      if (v_o) outs++;
      if (ready_o) rdy_ok++;
      chk("stream_data", data_o, elems[(i - 1) % 5]);
      tick();
    end
    chk("stream_beats", outs, 10);
    chk("stream_ready", rdy_ok, 10);
    v_i = 1'b0;
    look();
    chk("stream_last", data_o, elems[0]);
    tick();
    yumi_i = 1'b0;

    // select errors
    v_i = 1'b1; sel = 5'b00000;
    tick();
    sel = 5'b00110; yumi_i = 1'b1;
    look();
    chk("err_zero_data", data_o, 9'h000);
    chk("err_flag_first", err_o, CHK);
    tick();
    v_i = 1'b0;
    look();
    chk("err_multi_data", data_o, 9'h1FF);
    chk("err_cnt_two", err_cnt_o, CHK ? 2 : 0);
    tick();
    yumi_i = 1'b0;
    v_i = 1'b1; sel = 5'b11111;
    tick();
    yumi_i = 1'b1;
    for (int i = 0; i < 299; i++) tick();
    v_i = 1'b0;
    tick();
    yumi_i = 1'b0;
    look();
    chk("err_cnt_sat", err_cnt_o, CHK ? 8'hFF : 0);
    chk("err_flag_sticky", err_o, CHK);

    // reset while full
    v_i = 1'b1; sel = 5'b00001;
    tick();
    sel = 5'b00010;
    tick();
    look();
    chk("pre_rst_full", ready_o, 0);
    reset_i = 1'b1; yumi_i = 1'b1;
    tick();
    reset_i = 1'b0; yumi_i = 1'b0;
    v_i = 1'b1; sel = 5'b00100;
    look();
    chk("mid_rst_v_o", v_o, 0);
    chk("mid_rst_ready", ready_o, 1);
    chk("mid_rst_cnt", err_cnt_o, 0);
    tick();
    v_i = 1'b0;
    look();
    chk("post_rst_v_o", v_o, 1);
    chk("post_rst_data", data_o, 9'h1FF);
    yumi_i = 1'b1;
    tick();
    yumi_i = 1'b0;
    look();
    chk("post_rst_empty", v_o, 0);

    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
